// File: rtl/backward_layer.sv
// Backward pass of one fully connected signed-byte layer: delta_out = relu'(a) .* (W^T * delta).
// One MAC per clock, walking j (rows of W) fastest, then i (columns).
module backward_layer #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned AW    = 20,
  parameter int unsigned SHIFT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [N_OUT*N_IN*8-1:0] i_w,
  input  logic [N_OUT*8-1:0]      i_delta_in,
  input  logic [N_IN*8-1:0]       i_a_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N_IN*8-1:0]       o_delta_out
);

  localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] ILast = IW'(N_IN - 1);
  localparam logic [JW-1:0] JLast = JW'(N_OUT - 1);
  localparam logic signed [AW-1:0] SatMax = AW'(127);
  localparam logic signed [AW-1:0] SatMin = AW'(-128);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                  r_state, w_state_next;
  logic [N_OUT*N_IN*8-1:0] r_w;
  logic [N_OUT*8-1:0]      r_delta;
  logic [N_IN*8-1:0]       r_a;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  logic signed [AW-1:0]    r_acc;
  logic [N_IN*8-1:0]       r_res;
  logic [N_IN*8-1:0]       r_delta_out;

  logic signed [7:0]    w_wij, w_dj, w_ai, w_sat, w_res;
  logic signed [15:0]   w_prod;
  logic signed [AW-1:0] w_acc_next, w_shifted;
  logic [N_IN*8-1:0]    w_res_vec;
  logic                 w_last_j, w_last;

  // Operand muxes built as compares so narrow counters never index past the array.
  always_comb begin
    w_wij = '0;
    w_dj  = '0;
    w_ai  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (r_j == JW'(j)) begin
        w_dj = r_delta[j*8 +: 8];
        for (int i = 0; i < N_IN; i++) begin
          if (r_i == IW'(i)) w_wij = r_w[(j*N_IN+i)*8 +: 8];
        end
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (r_i == IW'(i)) w_ai = r_a[i*8 +: 8];
    end
  end

  always_comb begin
    w_prod     = w_wij * w_dj;
    w_acc_next = r_acc + {{(AW-16){w_prod[15]}}, w_prod};
    w_shifted  = w_acc_next >>> SHIFT;
    if (w_shifted > SatMax)      w_sat = 8'sd127;
    else if (w_shifted < SatMin) w_sat = -8'sd128;
    else                         w_sat = w_shifted[7:0];
    w_res    = (w_ai > 8'sd0) ? w_sat : 8'sd0;
    w_last_j = (r_j == JLast);
    w_last   = w_last_j && (r_i == ILast);
    w_res_vec = r_res;
    for (int i = 0; i < N_IN; i++) begin
      if (r_i == IW'(i)) w_res_vec[i*8 +: 8] = w_res;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StMac;
      StMac:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_w         <= '0;
      r_delta     <= '0;
      r_a         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_delta_out <= '0;
    end else if (r_state == StIdle && i_start) begin
      r_w     <= i_w;
      r_delta <= i_delta_in;
      r_a     <= i_a_in;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
    end else if (r_state == StMac) begin
      if (!w_last_j) begin
        r_j   <= r_j + JW'(1);
        r_acc <= w_acc_next;
      end else begin
        r_j   <= '0;
        r_acc <= '0;
        r_i   <= w_last ? '0 : r_i + IW'(1);
        r_res <= w_res_vec;
        if (w_last) r_delta_out <= w_res_vec;
      end
    end
  end

  assign o_busy      = (r_state == StMac);
  assign o_done      = (r_state == StDone);
  assign o_delta_out = r_delta_out;

endmodule

// File: tb/tb_backward_layer.sv
// Bench for backward_layer: three parameterisations, scoreboard queue of expected delta_out.
module tb_backward_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st0, st1, st2;
  logic [63:0] w0;
  logic [15:0] d0;
  logic [31:0] a0;
  logic [15:0] w2;
  logic [7:0]  d2;
  logic [15:0] a2;
  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] out0, out1;
  logic [15:0] out2;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  backward_layer #(.N_IN(4), .N_OUT(2), .AW(20), .SHIFT(0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(st0), .i_w(w0), .i_delta_in(d0), .i_a_in(a0),
    .o_busy(busy0), .o_done(done0), .o_delta_out(out0));

  backward_layer #(.N_IN(4), .N_OUT(2), .AW(20), .SHIFT(2)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(st1), .i_w(w0), .i_delta_in(d0), .i_a_in(a0),
    .o_busy(busy1), .o_done(done1), .o_delta_out(out1));

  backward_layer #(.N_IN(2), .N_OUT(1), .AW(20), .SHIFT(0)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(st2), .i_w(w2), .i_delta_in(d2), .i_a_in(a2),
    .o_busy(busy2), .o_done(done2), .o_delta_out(out2));

  localparam logic [63:0] WSpec = 64'h0703f8fc_06f80805;

  // Reference: integer sum of W[j][i]*delta[j], floor-free (SHIFT=0), clamp, ReLU mask.
  function automatic logic [31:0] model0(logic [63:0] w, logic [15:0] d, logic [31:0] a);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 2; j++) s += $signed(w[(j*4+i)*8 +: 8]) * $signed(d[j*8 +: 8]);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if ($signed(a[i*8 +: 8]) <= 0) s = 0;
      r[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands and start for one cycle (or leave start high); records the expectation.
  task automatic launch(input int which, input logic [63:0] w, input logic [15:0] d,
                        input logic [31:0] a, input logic [31:0] exp, input bit hold);
    exp_q.push_back(exp);
    case (which)
      0: begin w0 = w; d0 = d; a0 = a; st0 = 1'b1; end
      1: begin w0 = w; d0 = d; a0 = a; st1 = 1'b1; end
      default: begin w2 = w[15:0]; d2 = d[7:0]; a2 = a[15:0]; st2 = 1'b1; end
    endcase
    tick();
    if (!hold) begin
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    end
  endtask

  // Called in busy cycle 1; returns the cycle number at which done is seen (bounded).
  task automatic wait_done(input int which, output int cyc, output int nbusy, output bit both);
    logic b, dn;
    cyc = 1; nbusy = 0; both = 1'b0;
    while (cyc < 40) begin
      case (which)
        0: begin b = busy0; dn = done0; end
        1: begin b = busy1; dn = done1; end
        default: begin b = busy2; dn = done2; end
      endcase
      if (b && dn) both = 1'b1;
      if (dn) break;
      if (b) nbusy++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; st0 = 0; st1 = 0; st2 = 0;
    w0 = '0; d0 = '0; a0 = '0; w2 = '0; d2 = '0; a2 = '0;
    repeat (3) tick();
    checks++;
    if ({busy0, done0, out0} !== 34'd0) begin
      failures++; $display("FAIL reset_dut0 got busy=%b done=%b out=%h want 0 0 0", busy0, done0, out0);
    end
    checks++;
    if ({busy1, done1, out1} !== 34'd0) begin
      failures++; $display("FAIL reset_dut1 got busy=%b done=%b out=%h want 0 0 0", busy1, done1, out1);
    end
    checks++;
    if ({busy2, done2, out2} !== 18'd0) begin
      failures++; $display("FAIL reset_dut2 got busy=%b done=%b out=%h want 0 0 0", busy2, done2, out2);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_spec_vectors();
    int cyc, nb;
    bit both;
    logic [31:0] e;
    logic [15:0] dv[3];
    logic [31:0] av[3], ev[3];
    dv[0] = 16'h0101; av[0] = 32'h01010101; ev[0] = 32'h0dfb0001;
    dv[1] = 16'h0101; av[1] = 32'h02fd0500; ev[1] = 32'h0d000000;
    dv[2] = 16'h7f7f; av[2] = 32'h01010101; ev[2] = 32'h7f80007f;
    for (int k = 0; k < 3; k++) begin
      launch(0, WSpec, dv[k], av[k], ev[k], 1'b0);
      wait_done(0, cyc, nb, both);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 9) begin failures++; $display("FAIL latency%0d got %0d want 9", k, cyc); end
      checks++;
      if (nb !== 8) begin failures++; $display("FAIL busy_cycles%0d got %0d want 8", k, nb); end
      checks++;
      if (both) begin failures++; $display("FAIL busy_done_overlap%0d got 1 want 0", k); end
      checks++;
      if (out0 !== e) begin failures++; $display("FAIL vector%0d got %h want %h", k, out0, e); end
      tick();
    end
  endtask

  task automatic test_shift();
    int cyc, nb;
    bit both;
    logic [31:0] e;
    launch(1, WSpec, 16'h0101, 32'h01010101, 32'h03fe0000, 1'b0);
    wait_done(1, cyc, nb, both);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL shift_latency got %0d want 9", cyc); end
    checks++;
    if (out1 !== e) begin failures++; $display("FAIL shift_result got %h want %h", out1, e); end
    tick();
  endtask

  task automatic test_small();
    int cyc, nb;
    bit both;
    logic [31:0] e;
    launch(2, 64'h0509, 16'h02, 32'h0103, 32'h0a12, 1'b0);
    wait_done(2, cyc, nb, both);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL small_latency got %0d want 3", cyc); end
    checks++;
    if (nb !== 2) begin failures++; $display("FAIL small_busy got %0d want 2", nb); end
    checks++;
    if (out2 !== e[15:0]) begin failures++; $display("FAIL small_result got %h want %h", out2, e[15:0]); end
    tick();
  endtask

  task automatic test_hold_and_ignore();
    int cyc, nb;
    bit both;
    logic [31:0] e;
    launch(0, WSpec, 16'h0101, 32'h01010101, 32'h0dfb0001, 1'b0);
    tick();
    // Extra start pulse mid-run with different operands must be ignored.
    w0 = '0; d0 = 16'h7f7f; a0 = '0; st0 = 1'b1;
    tick();
    st0 = 1'b0;
    wait_done(0, cyc, nb, both);
    cyc += 2;
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL ignore_latency got %0d want 9", cyc); end
    checks++;
    if (out0 !== e) begin failures++; $display("FAIL ignore_result got %h want %h", out0, e); end
    repeat (3) tick();
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      failures++; $display("FAIL no_rerun got busy=%b done=%b want 0 0", busy0, done0);
    end
    checks++;
    if (out0 !== e) begin failures++; $display("FAIL hold_output got %h want %h", out0, e); end
  endtask

  task automatic test_reset_mid_run();
    launch(0, WSpec, 16'h7f7f, 32'h01010101, 32'h7f80007f, 1'b0);
    exp_q.delete();
    tick();
    tick();
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL mid_busy got %b want 1", busy0); end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy0, done0, out0} !== 34'd0) begin
      failures++; $display("FAIL mid_reset got busy=%b done=%b out=%h want 0 0 0", busy0, done0, out0);
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy0, done0, out0} !== 34'd0) begin
      failures++; $display("FAIL after_reset got busy=%b done=%b out=%h want 0 0 0", busy0, done0, out0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    bit both;
    logic [31:0] e;
    launch(0, WSpec, 16'h0101, 32'h01010101, 32'h0dfb0001, 1'b1);
    // Operands change after sampling while start stays high.
    w0 = 64'h0102030405060708; d0 = 16'h0203; a0 = 32'h01ff0101;
    wait_done(0, cyc, nb, both);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL b2b_latency got %0d want 9", cyc); end
    checks++;
    if (out0 !== e) begin failures++; $display("FAIL b2b_first got %h want %h", out0, e); end
    tick();
    checks++;
    if ({busy0, done0} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy0, done0);
    end
    exp_q.push_back(model0(w0, d0, a0));
    tick();
    st0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_restart got %b want 1", busy0); end
    wait_done(0, cyc, nb, both);
    e = exp_q.pop_front();
    checks++;
    if (cyc !== 9) begin failures++; $display("FAIL b2b_latency2 got %0d want 9", cyc); end
    checks++;
    if (out0 !== e) begin failures++; $display("FAIL b2b_second got %h want %h", out0, e); end
    tick();
  endtask

  task automatic test_random();
    int cyc, nb;
    bit both;
    logic [63:0] w;
    logic [15:0] d;
    logic [31:0] a, e;
    for (int k = 0; k < 6; k++) begin
      w = {$urandom, $urandom};
      d = 16'($urandom);
      a = $urandom;
      launch(0, w, d, a, model0(w, d, a), 1'b0);
      wait_done(0, cyc, nb, both);
      e = exp_q.pop_front();
      checks++;
      if (out0 !== e || cyc !== 9) begin
        failures++;
        $display("FAIL random%0d got %h (cycle %0d) want %h (cycle 9)", k, out0, cyc, e);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_shift();
    test_small();
    test_hold_and_ignore();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
